// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add multiplier: one shared adder, WORD_LENGTH iterations, ready pulses WORD_LENGTH+1 cycles after accept; start is ignored while busy.
// Define SIGNED_MULT_EN for two's-complement operands (magnitudes iterate, sign applied on the DONE-entry edge).
module shift_add_multiplier #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WORD_LENGTH-1:0]     multiplicand,
    input  logic [WORD_LENGTH-1:0]     multiplier,
    output logic [2*WORD_LENGTH-1:0]   product,
    output logic                       busy,
    output logic                       ready
);

    localparam int PW = 2 * WORD_LENGTH;
    localparam int CW = $clog2(WORD_LENGTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [PW-1:0]          r_mcand;
    logic [PW-1:0]          r_acc;
    logic [PW-1:0]          r_product;
    logic [WORD_LENGTH-1:0] r_mplier;
    logic [CW-1:0]          r_count;

    logic                   w_last;
    logic [PW-1:0]          w_addend;
    logic [PW-1:0]          w_acc_next;
    logic [PW-1:0]          w_result;
    logic [WORD_LENGTH-1:0] w_mag_a;
    logic [WORD_LENGTH-1:0] w_mag_b;

    assign w_last     = (r_count == CW'(1));
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

`ifdef SIGNED_MULT_EN
    logic r_neg;
    logic w_neg;

    // Magnitude of the most-negative value is 2^(W-1), which still fits W unsigned bits.
    assign w_mag_a  = multiplicand[WORD_LENGTH-1] ? -multiplicand : multiplicand;
    assign w_mag_b  = multiplier[WORD_LENGTH-1]   ? -multiplier   : multiplier;
    assign w_neg    = multiplicand[WORD_LENGTH-1] ^ multiplier[WORD_LENGTH-1];
    assign w_result = r_neg ? -w_acc_next : w_acc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_neg <= w_neg;
        end
    end
`else
    assign w_mag_a  = multiplicand;
    assign w_mag_b  = multiplier;
    assign w_result = w_acc_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        ready        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                ready        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WORD_LENGTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_count  <= CW'(WORD_LENGTH);
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CW'(1);
                    // Final iteration's sum goes straight to the output register.
                    if (w_last) begin
                        r_product <= w_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule
